// File: rtl/unified_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// unified_mem_arbiter_pkg : shared response-state encoding and default sizes
// Revision: 1.0
// ============================================================================
package unified_mem_arbiter_pkg;

    localparam int DEF_ADDR_W      = 32;
    localparam int DEF_DATA_W      = 32;
    localparam int DEF_MAX_D_BURST = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RESP_I = 2'd1,
        RESP_D = 2'd2
    } resp_state_t;

    // A zero-length burst still needs a one-bit counter
    function automatic int cnt_width(input int max_burst);
        return (max_burst < 1) ? 1 : $clog2(max_burst + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/unified_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// unified_mem_arbiter_if : instruction, data and shared-memory port bundle
// Revision: 1.0
// ============================================================================
interface unified_mem_arbiter_if
    import unified_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) ();

    logic              I_REQ;
    logic [ADDR_W-1:0] I_ADDR;
    logic              I_GNT;
    logic              I_RVALID;
    logic [DATA_W-1:0] I_RDATA;

    logic              D_REQ;
    logic              D_WE;
    logic [ADDR_W-1:0] D_ADDR;
    logic [DATA_W-1:0] D_WDATA;
    logic              D_GNT;
    logic              D_RVALID;
    logic [DATA_W-1:0] D_RDATA;

    logic              M_READY;
    logic              M_REQ;
    logic              M_WE;
    logic [ADDR_W-1:0] M_ADDR;
    logic [DATA_W-1:0] M_WDATA;
    logic [DATA_W-1:0] M_RDATA;

    modport slave (
        input  I_REQ, I_ADDR, D_REQ, D_WE, D_ADDR, D_WDATA, M_READY, M_RDATA,
        output I_GNT, I_RVALID, I_RDATA, D_GNT, D_RVALID, D_RDATA,
        output M_REQ, M_WE, M_ADDR, M_WDATA
    );

    modport master (
        output I_REQ, I_ADDR, D_REQ, D_WE, D_ADDR, D_WDATA, M_READY, M_RDATA,
        input  I_GNT, I_RVALID, I_RDATA, D_GNT, D_RVALID, D_RDATA,
        input  M_REQ, M_WE, M_ADDR, M_WDATA
    );

endinterface
`default_nettype wire

// File: rtl/unified_mem_arbiter_fair_cnt.sv
`default_nettype none
// ============================================================================
// mem_arb_fair_cnt : counts data grants taken while the fetch port waits
// Revision: 1.0
// ============================================================================
module mem_arb_fair_cnt
    import unified_mem_arbiter_pkg::*;
#(
    parameter int MAX_D_BURST = DEF_MAX_D_BURST
) (
    input  wire logic clk_i,
    input  wire logic rst_n_i,
    input  wire logic i_req_i,
    input  wire logic i_gnt_i,
    input  wire logic d_gnt_i,
    output logic      limit_o
);

    localparam int             CNT_W = cnt_width(MAX_D_BURST);
    localparam logic [CNT_W-1:0] C_MAX = CNT_W'(MAX_D_BURST);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_gnt_i || !i_req_i) begin
            cnt_d = '0;
        end else if (d_gnt_i && (cnt_q != C_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign limit_o = (cnt_q == C_MAX);

endmodule
`default_nettype wire

// File: rtl/unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
// unified_mem_arbiter : shares one memory port between fetch and data traffic
// Revision: 1.0
// ============================================================================
module unified_mem_arbiter
    import unified_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int MAX_D_BURST = DEF_MAX_D_BURST
) (
    input  wire logic             CLK,
    input  wire logic             ASYNC_RSTn,
    input  wire logic             EN,
    unified_mem_arbiter_if.slave  bus
);

    logic              w_ok;
    logic              w_i_win;
    logic              w_i_gnt;
    logic              w_d_gnt;
    logic              w_limit;
    logic              w_m_we;
    logic [ADDR_W-1:0] w_m_addr;
    logic [DATA_W-1:0] w_m_wdata;
    resp_state_t       state_q;
    resp_state_t       state_d;

    mem_arb_fair_cnt #(
        .MAX_D_BURST (MAX_D_BURST)
    ) u_fair (
        .clk_i   (CLK),
        .rst_n_i (ASYNC_RSTn),
        .i_req_i (bus.I_REQ),
        .i_gnt_i (w_i_gnt),
        .d_gnt_i (w_d_gnt),
        .limit_o (w_limit)
    );

    // Data normally wins; a waiting fetch takes over once the burst limit is hit
    assign w_ok    = EN & bus.M_READY;
    assign w_i_win = bus.I_REQ & (~bus.D_REQ | w_limit);
    assign w_i_gnt = w_ok & w_i_win;
    assign w_d_gnt = w_ok & bus.D_REQ & ~w_i_win;

    always_comb begin
        w_m_we    = 1'b0;
        w_m_addr  = '0;
        w_m_wdata = '0;
        if (w_i_gnt) begin
            w_m_addr  = bus.I_ADDR;
        end else if (w_d_gnt) begin
            w_m_we    = bus.D_WE;
            w_m_addr  = bus.D_ADDR;
            w_m_wdata = bus.D_WDATA;
        end
    end

    always_comb begin
        state_d = IDLE;
        if (w_i_gnt) begin
            state_d = RESP_I;
        end else if (w_d_gnt && !bus.D_WE) begin
            state_d = RESP_D;
        end
    end

    always_ff @(posedge CLK or negedge ASYNC_RSTn) begin
        if (!ASYNC_RSTn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign bus.I_GNT    = w_i_gnt;
    assign bus.D_GNT    = w_d_gnt;
    assign bus.M_REQ    = w_i_gnt | w_d_gnt;
    assign bus.M_WE     = w_m_we;
    assign bus.M_ADDR   = w_m_addr;
    assign bus.M_WDATA  = w_m_wdata;
    assign bus.I_RVALID = (state_q == RESP_I);
    assign bus.D_RVALID = (state_q == RESP_D);
    assign bus.I_RDATA  = bus.M_RDATA;
    assign bus.D_RDATA  = bus.M_RDATA;

endmodule
`default_nettype wire

// File: tb/tb_unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_unified_mem_arbiter : scoreboard bench for the unified memory arbiter
// Revision: 1.0
// ============================================================================
module tb_unified_mem_arbiter;

    localparam int C_MAX = 4;

    typedef struct {
        int          kind;   // 0 none, 1 fetch response, 2 data response
        logic [31:0] data;
    } resp_t;

    logic CLK = 1'b0;
    logic ASYNC_RSTn;
    logic EN;
    logic m_ready;
    int   n_vec = 0;
    int   n_err = 0;
    int   fcnt  = 0;
    logic        mem_rd;
    logic [31:0] mem_addr;
    resp_t       sb[$];

    unified_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    unified_mem_arbiter #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .MAX_D_BURST (C_MAX)
    ) u_dut (
        .CLK        (CLK),
        .ASYNC_RSTn (ASYNC_RSTn),
        .EN         (EN),
        .bus        (bus)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a == 32'h10) ? 32'hDEADBEEF : ((a * 32'h9E3779B1) ^ 32'h5A5A_0000);
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One bus cycle: drive, compare at the falling edge, then advance the model
    task automatic step(input logic en, input logic ireq, input logic [31:0] iaddr,
                        input logic dreq, input logic dwe, input logic [31:0] daddr,
                        input logic [31:0] wdata);
        logic  ok, iwin, ei, ed;
        resp_t cur;
        resp_t nxt;
        EN           = en;
        bus.M_READY  = m_ready;
        bus.I_REQ    = ireq;
        bus.I_ADDR   = iaddr;
        bus.D_REQ    = dreq;
        bus.D_WE     = dwe;
        bus.D_ADDR   = daddr;
        bus.D_WDATA  = wdata;
        ok   = en && m_ready;
        iwin = ireq && (!dreq || (fcnt == C_MAX));
        ei   = ok && iwin;
        ed   = ok && dreq && !iwin;
        @(negedge CLK);
        chk("i_gnt", 64'(bus.I_GNT), 64'(ei));
        chk("d_gnt", 64'(bus.D_GNT), 64'(ed));
        chk("m_req", 64'(bus.M_REQ), 64'(ei || ed));
        chk("m_we", 64'(bus.M_WE), 64'(ed && dwe));
        chk("m_addr", 64'(bus.M_ADDR), ei ? 64'(iaddr) : (ed ? 64'(daddr) : 64'd0));
        chk("m_wdata", 64'(bus.M_WDATA), ed ? 64'(wdata) : 64'd0);
        if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard: got empty queue expected one entry");
        end else begin
            cur = sb.pop_front();
            chk("i_rvalid", 64'(bus.I_RVALID), 64'(cur.kind == 1));
            chk("d_rvalid", 64'(bus.D_RVALID), 64'(cur.kind == 2));
            if (cur.kind == 1) chk("i_rdata", 64'(bus.I_RDATA), 64'(cur.data));
            if (cur.kind == 2) chk("d_rdata", 64'(bus.D_RDATA), 64'(cur.data));
        end
        mem_rd   = bus.M_REQ && !bus.M_WE;
        mem_addr = bus.M_ADDR;
        nxt.kind = ei ? 1 : ((ed && !dwe) ? 2 : 0);
        nxt.data = memfn(ei ? iaddr : daddr);
        sb.push_back(nxt);
        if (ei || !ireq) fcnt = 0;
        else if (ed && fcnt < C_MAX) fcnt = fcnt + 1;
        @(posedge CLK);
        #1;
        bus.M_RDATA = mem_rd ? memfn(mem_addr) : 32'd0;
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic rst_pulse();
        resp_t none;
        ASYNC_RSTn = 1'b0;
        bus.I_REQ  = 1'b0;
        bus.D_REQ  = 1'b0;
        #1;
        chk("rst_d_rvalid", 64'(bus.D_RVALID), 64'd0);
        chk("rst_i_rvalid", 64'(bus.I_RVALID), 64'd0);
        chk("rst_fair_cnt", 64'(u_dut.u_fair.cnt_q), 64'd0);
        #1;
        ASYNC_RSTn  = 1'b1;
        fcnt        = 0;
        bus.M_RDATA = 32'd0;
        sb.delete();
        none.kind = 0;
        none.data = 32'd0;
        sb.push_back(none);
    endtask

    initial begin
        resp_t none;
        ASYNC_RSTn  = 1'b0;
        EN          = 1'b0;
        m_ready     = 1'b0;
        bus.M_READY = 1'b0;
        bus.I_REQ   = 1'b0;
        bus.I_ADDR  = '0;
        bus.D_REQ   = 1'b0;
        bus.D_WE    = 1'b0;
        bus.D_ADDR  = '0;
        bus.D_WDATA = '0;
        bus.M_RDATA = '0;
        repeat (2) @(posedge CLK);
        #1;
        chk("reset_i_rvalid", 64'(bus.I_RVALID), 64'd0);
        chk("reset_d_rvalid", 64'(bus.D_RVALID), 64'd0);
        chk("reset_fair_cnt", 64'(u_dut.u_fair.cnt_q), 64'd0);
        ASYNC_RSTn = 1'b1;
        none.kind = 0;
        none.data = 32'd0;
        sb.push_back(none);

        // memory not ready blocks both ports, then data wins
        step(1'b1, 1'b1, 32'h100, 1'b1, 1'b0, 32'h200, 32'd0);
        m_ready = 1'b1;
        step(1'b1, 1'b1, 32'h104, 1'b1, 1'b0, 32'h204, 32'd0);

        // lone fetch returns DEADBEEF one cycle later
        step(1'b1, 1'b1, 32'h10, 1'b0, 1'b0, 32'd0, 32'd0);
        idle();

        // enable low blocks grants
        step(1'b0, 1'b1, 32'h108, 1'b1, 1'b0, 32'h208, 32'd0);

        // contention: D,D,D,D,I repeating
        for (int k = 0; k < 10; k++)
            step(1'b1, 1'b1, 32'h300 + 32'(4 * k), 1'b1, 1'b0, 32'h400 + 32'(4 * k), 32'd0);
        idle();

        // response still delivered when EN drops in the response cycle
        step(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'h500, 32'd0);
        step(1'b0, 1'b1, 32'h44, 1'b1, 1'b0, 32'h48, 32'd0);

        // data write: strobe out, no read response
        step(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 32'h20, 32'h5A);
        idle();

        // reset in the response cycle of a data read
        step(1'b1, 1'b1, 32'h60, 1'b1, 1'b0, 32'h64, 32'd0);
        rst_pulse();
        idle();

        // alternating fetch/data reads, back to back
        for (int k = 0; k < 8; k++)
            step(1'b1, (k % 2) == 0, 32'h700 + 32'(8 * k), (k % 2) == 1, 1'b0,
                 32'h800 + 32'(8 * k), 32'd0);
        idle();

        // random traffic
        for (int k = 0; k < 60; k++) begin
            m_ready = ($urandom_range(7) != 0);
            step($urandom_range(3) != 0, 1'($urandom_range(1)), $urandom,
                 1'($urandom_range(1)), 1'($urandom_range(1)), $urandom, $urandom);
        end
        m_ready = 1'b1;
        idle();
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/unified_mem_arbiter.md
UNIFIED_MEM_ARBITER -- requirements
Module: unified_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning address width of all ports.
REQ-002 SHALL have parameter DATA_W, default 32, meaning data width of all ports.
REQ-003 SHALL have parameter MAX_D_BURST, default 4, meaning max consecutive data grants while instruction port waits.
REQ-004 SHALL have port CLK  in  1  the single clock; all state rising-edge.
REQ-005 SHALL have port ASYNC_RSTn  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port EN  in  1  enable; low blocks new grants.
REQ-007 SHALL have port I_REQ  in  1  instruction fetch request.
REQ-008 SHALL have port I_ADDR  in  ADDR_W  fetch address.
REQ-009 SHALL have port I_GNT  out  1  fetch accepted this cycle.
REQ-010 SHALL have port I_RVALID  out  1  fetch data valid.
REQ-011 SHALL have port I_RDATA  out  DATA_W  fetch data.
REQ-012 SHALL have port D_REQ  in  1  data request.
REQ-013 SHALL have port D_WE  in  1  data write (1) / read (0).
REQ-014 SHALL have port D_ADDR  in  ADDR_W  data address.
REQ-015 SHALL have port D_WDATA  in  DATA_W  write data.
REQ-016 SHALL have port D_GNT  out  1  data request accepted this cycle.
REQ-017 SHALL have port D_RVALID  out  1  read data valid.
REQ-018 SHALL have port D_RDATA  out  DATA_W  read data.
REQ-019 SHALL have port M_READY  in  1  shared memory initialised.
REQ-020 SHALL have port M_REQ  out  1  memory access strobe.
REQ-021 SHALL have port M_WE  out  1  memory write strobe.
REQ-022 SHALL have port M_ADDR  out  ADDR_W  memory address.
REQ-023 SHALL have port M_WDATA  out  DATA_W  memory write data.
REQ-024 SHALL have port M_RDATA  in  DATA_W  memory read data, valid one cycle after read strobe.

Function
REQ-025 SHALL assert at most one of I_GNT/D_GNT per cycle; grants combinational from requests, EN, M_READY and fairness state.
REQ-026 SHALL grant nothing while EN=0 or M_READY=0.
REQ-027 SHALL prioritise D_REQ over I_REQ, except when fairness count equals MAX_D_BURST and I_REQ=1, then I wins.
REQ-028 SHALL increment fairness count on each D grant while I_REQ=1; clear on I grant or when I_REQ=0; saturate at MAX_D_BURST.
REQ-029 SHALL drive M_REQ=grant, M_ADDR/M_WE/M_WDATA from granted port; all M_* outputs 0 when no grant; M_WE=0 for I grants.
REQ-030 SHALL use response FSM states IDLE, RESP_I, RESP_D; next state RESP_I after I grant, RESP_D after D read grant, else IDLE.
REQ-031 SHALL assert I_RVALID in RESP_I, D_RVALID in RESP_D, exactly one cycle after the grant; writes produce no RVALID.
REQ-032 SHALL drive I_RDATA and D_RDATA = M_RDATA unconditionally (qualified by RVALID).
REQ-033 SHALL support back-to-back grants: a new grant in the same cycle a response is delivered; throughput one access/cycle.
REQ-034 SHALL deliver a pending response even if EN falls in the response cycle.
REQ-035 SHALL give MAX_D_BURST=0 strict instruction priority.

Reset
REQ-036 SHALL on ASYNC_RSTn=0 force state IDLE, fairness count 0, RVALIDs 0, independent of CLK.
REQ-037 SHALL drop any pending response on reset mid-operation; no RVALID in the first cycle after release.

Structure
REQ-038 SHALL place response state encoding and default widths/MAX_D_BURST constant in the shared riscv package.
REQ-039 SHALL implement fairness counter as sub-module mem_arb_fair_cnt; FSM and muxing in top.

Verification
REQ-040 SHALL test: M_READY=0, I_REQ=D_REQ=1 -> no grant, M_REQ=0; M_READY=1 next -> D_GNT=1.
REQ-041 SHALL test: I_REQ=1 addr 0x10 alone, M_RDATA=0xDEADBEEF next cycle -> I_RVALID=1, I_RDATA=0xDEADBEEF one cycle after grant.
REQ-042 SHALL test: I_REQ and D_REQ held high 10 cycles, MAX_D_BURST=4 -> grant pattern D,D,D,D,I repeating.
REQ-043 SHALL test: D write addr 0x20 data 0x5A -> M_WE=1, M_WDATA=0x5A, no D_RVALID next cycle.
REQ-044 SHALL test: ASYNC_RSTn pulsed low mid-cycle after D read grant -> D_RVALID stays 0, count 0.
REQ-045 SHALL test: alternating I/D reads every cycle -> RVALID alternates, each matches its grant's address data.
